// File: rtl/mpu_result_collector_if.sv
// mpu_result_collector_if
//   Groups the two handshakes around the result collector:
//   - MPU byte-readout port: mpu_flag/mpu_byte_idx/mpu_data from the MPU,
//     mpu_ack level back to it.
//   - Result port: result/result_valid to the next stage, result_ready back.
//   Modports:
//     slave  - collector view (consumes MPU bytes, produces the word)
//     master - environment view (MPU model plus downstream consumer)
interface mpu_result_collector_if #(
  parameter int N_BYTES = 25,
  parameter int BYTE_W  = 8
);
  logic                        mpu_flag;
  logic [4:0]                  mpu_byte_idx;
  logic [BYTE_W-1:0]           mpu_data;
  logic                        mpu_ack;
  logic [N_BYTES*BYTE_W-1:0]   result;
  logic                        result_valid;
  logic                        result_ready;

  modport slave (
    input  mpu_flag, mpu_byte_idx, mpu_data, result_ready,
    output mpu_ack, result, result_valid
  );

  modport master (
    output mpu_flag, mpu_byte_idx, mpu_data, result_ready,
    input  mpu_ack, result, result_valid
  );
endinterface

// File: rtl/mpu_result_collector.sv
// mpu_result_collector
//   Downstream consumer of the MPU byte-readout port. Runs the ack half of the
//   four-phase flag/ack handshake, assembles N_BYTES bytes (byte 0 = LSB) into
//   one wide word and offers it to the next stage with valid/ready.
//   Ports:
//     clock        - system clock, rising edge
//     reset        - synchronous, active-high
//     arm          - pulse: start collecting a readout (ignored while busy)
//     abort        - pulse: drop the current readout, return to idle
//     bus          - slave side of mpu_result_collector_if (MPU port + result port)
//     busy         - not idle
//     seq_error    - sticky until next arm: a byte arrived with an unexpected index
//     timeout_err  - sticky until next arm: flag wait exceeded TIMEOUT cycles
module mpu_result_collector #(
  parameter int N_BYTES = 25,
  parameter int BYTE_W  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  abort,
  mpu_result_collector_if.slave bus,
  output logic                  busy,
  output logic                  seq_error,
  output logic                  timeout_err
);

  localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int WORD_W = N_BYTES * BYTE_W;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_BYTES - 1);
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FLAG,
    ACK_HI,
    ACK_LO,
    PRESENT
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   exp_idx;
  logic [TMR_W-1:0]   timer;
  logic               ack_q;
  logic               valid_q;
  logic [WORD_W-1:0]  result_q;
  logic               seq_q;
  logic               to_q;

  logic ack_next;
  logic valid_next;
  logic capture;
  logic idx_clear;
  logic idx_inc;
  logic timer_clear;
  logic timer_inc;
  logic errors_clear;
  logic seq_set;
  logic to_set;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath strobes. Abort takes priority over everything in
  // the busy states; in IDLE it simply suppresses a coincident arm.
  always_comb begin
    state_next   = state;
    ack_next     = ack_q;
    valid_next   = valid_q;
    capture      = 1'b0;
    idx_clear    = 1'b0;
    idx_inc      = 1'b0;
    timer_clear  = 1'b0;
    timer_inc    = 1'b0;
    errors_clear = 1'b0;
    seq_set      = 1'b0;
    to_set       = 1'b0;

    case (state)
      IDLE: begin
        if (arm && !abort) begin
          state_next   = WAIT_FLAG;
          errors_clear = 1'b1;
          idx_clear    = 1'b1;
          timer_clear  = 1'b1;
        end
      end

      WAIT_FLAG: begin
        if (abort) begin
          state_next = IDLE;
          ack_next   = 1'b0;
        end else if (bus.mpu_flag) begin
          // Data always lands at the expected slot; a wrong index only flags.
          capture     = 1'b1;
          seq_set     = (bus.mpu_byte_idx != 5'(exp_idx));
          ack_next    = 1'b1;
          timer_clear = 1'b1;
          state_next  = ACK_HI;
        end else if (timer == TIMER_LAST) begin
          to_set     = 1'b1;
          ack_next   = 1'b0;
          state_next = IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end

      ACK_HI: begin
        if (abort) begin
          state_next = IDLE;
          ack_next   = 1'b0;
        end else if (!bus.mpu_flag) begin
          ack_next   = 1'b0;
          state_next = ACK_LO;
        end else if (timer == TIMER_LAST) begin
          to_set     = 1'b1;
          ack_next   = 1'b0;
          state_next = IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end

      // One guaranteed low cycle so the MPU sees a clean ack falling edge.
      ACK_LO: begin
        if (abort) begin
          state_next = IDLE;
        end else if (exp_idx == IDX_LAST) begin
          valid_next = 1'b1;
          state_next = PRESENT;
        end else begin
          idx_inc     = 1'b1;
          timer_clear = 1'b1;
          state_next  = WAIT_FLAG;
        end
      end

      PRESENT: begin
        if (abort) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end else if (bus.result_ready) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        ack_next   = 1'b0;
        valid_next = 1'b0;
      end
    endcase
  end

  // Datapath registers driven by the strobes above.
  always_ff @(posedge clock) begin
    if (reset) begin
      exp_idx  <= '0;
      timer    <= '0;
      ack_q    <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      seq_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      ack_q   <= ack_next;
      valid_q <= valid_next;

      if (idx_clear) begin
        exp_idx <= '0;
      end else if (idx_inc) begin
        exp_idx <= exp_idx + 1'b1;
      end

      if (timer_clear) begin
        timer <= '0;
      end else if (timer_inc) begin
        timer <= timer + 1'b1;
      end

      if (errors_clear) begin
        seq_q <= 1'b0;
      end else if (seq_set) begin
        seq_q <= 1'b1;
      end

      if (errors_clear) begin
        to_q <= 1'b0;
      end else if (to_set) begin
        to_q <= 1'b1;
      end

      // Per-byte write enable decoded from the expected index.
      for (int b = 0; b < N_BYTES; b++) begin
        if (capture && (exp_idx == IDX_W'(b))) begin
          result_q[b*BYTE_W +: BYTE_W] <= bus.mpu_data;
        end
      end
    end
  end

  assign bus.mpu_ack      = ack_q;
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign busy             = (state != IDLE);
  assign seq_error        = seq_q;
  assign timeout_err      = to_q;

endmodule
